pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 512, operand/result width in bits.
REQ-002 The block SHALL have parameter SEGS, default 4, number of carry-pipelined segments; legal when WIDTH % SEGS == 0, SEGS >= 1.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand beat present.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts beat this cycle.
REQ-007 The block SHALL have port din_one, input, WIDTH, first operand.
REQ-008 The block SHALL have port din_two, input, WIDTH, second operand.
REQ-009 The block SHALL have port cin, input, 1, carry-in (add) or borrow-in (sub).
REQ-010 The block SHALL have port sub, input, 1, 0 = add, 1 = subtract.
REQ-011 The block SHALL have port out_valid, output, 1, result beat present.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 The block SHALL have port sum, output, WIDTH, result.
REQ-014 The block SHALL have port cout, output, 1, carry-out (add) or not-borrow (sub).
REQ-015 The block SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-016 Add: {cout,sum} SHALL equal din_one + din_two + cin, full WIDTH+1-bit result.
REQ-017 Sub: {cout,sum} SHALL equal din_one + ~din_two + ~cin; cout=1 means no borrow.
REQ-018 ovf SHALL be 1 iff the MSBs of din_one and the effective second operand (din_two, or ~din_two in sub) match and differ from sum MSB.
REQ-019 Operands SHALL be split into SEGS segments of WIDTH/SEGS bits; segment k SHALL be added in stage k using the registered carry from stage k-1 (stage 0 uses cin ^ sub).
REQ-020 Segment k input SHALL be delayed k cycles (skew); result segment k SHALL be delayed SEGS-1-k cycles (deskew) so all segments of a beat emerge together.
REQ-021 A beat SHALL transfer in when in_valid && in_ready; out when out_valid && out_ready.
REQ-022 Latency SHALL be exactly SEGS cycles from input transfer to out_valid, with no stall.
REQ-023 Throughput SHALL be one beat per cycle; back-to-back beats allowed with no bubbles.
REQ-024 Stall = out_valid && !out_ready; during stall every pipeline register SHALL hold and in_ready SHALL be 0.
REQ-025 in_ready SHALL be !stall (combinational from out_valid, out_ready only; no path from in_valid).
REQ-026 sum, cout, ovf SHALL be stable while out_valid && !out_ready.
REQ-027 Beats SHALL exit in acceptance order; none dropped or duplicated.
REQ-028 A per-stage valid bit SHALL track each beat; invalid stages may load data but SHALL never raise out_valid.

Reset
REQ-029 rst_n low SHALL asynchronously clear all valid bits, carries, sum, cout, ovf to 0.
REQ-030 Beats in flight at reset SHALL be discarded; out_valid SHALL be 0 from reset assertion until SEGS cycles after the first post-reset transfer.

Structure
REQ-031 Package pipe_adder_pkg SHALL hold default constants PA_WIDTH=512, PA_SEGS=4 and a segment-width function.
REQ-032 One sub-module pipe_adder_seg SHALL implement one registered segment (seg operands, carry in -> registered seg sum, carry out, valid, enable).

Verification
REQ-033 WIDTH=512, SEGS=4: din_one=all-ones, din_two=0, cin=1, sub=0 -> 4 cycles later sum=0, cout=1, ovf=0.
REQ-034 sub=1, cin=0, din_one=5, din_two=7 -> sum=2^512-2, cout=0, ovf=0.
REQ-035 din_one=0x7FF...F, din_two=1, cin=0, sub=0 -> sum=0x800...0, ovf=1, cout=0.
REQ-036 8 back-to-back random beats, out_ready low cycles 5-7 -> in_ready low those cycles, all 8 results match model in order.
REQ-037 3 beats in flight, rst_n pulsed low -> out_valid 0 immediately, no stale result after release.
REQ-038 WIDTH=64, SEGS=1 and SEGS=8 -> latency 1 and 8 respectively, 10k random add/sub beats match model.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the carry-pipelined adder.
package pipe_adder_pkg;

    localparam int PA_WIDTH = 512;
    localparam int PA_SEGS  = 4;

    // Width of one carry-pipelined segment.
    function automatic int seg_width(input int width, input int segs);
        return width / segs;
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One registered adder segment: adds its operand slice plus the incoming
// carry and registers the slice sum, carry-out and the beat's valid bit.
// Only the most-significant segment produces a signed-overflow flag; all
// other segments hold theirs at 0 so the top can simply OR them together.
module pipe_adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int SEG_W   = 128,
    parameter bit MSB_SEG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vld_in,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             c_in,
    output logic [SEG_W-1:0] sum_q,
    output logic             c_out_q,
    output logic             ovf_q,
    output logic             vld_q
);

    logic [SEG_W:0]   raw;
    logic [SEG_W-1:0] sum_d;
    logic             c_out_d;
    logic             ovf_d;
    logic             vld_d;
    logic             ovf_raw;

    // Slice addition; everything holds when the pipeline is stalled.
    always_comb begin
        raw     = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, c_in};
        ovf_raw = MSB_SEG && (a[SEG_W-1] == b[SEG_W-1]) && (raw[SEG_W-1] != a[SEG_W-1]);
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        if (en) begin
            sum_d   = raw[SEG_W-1:0];
            c_out_d = raw[SEG_W];
            ovf_d   = ovf_raw;
            vld_d   = vld_in;
        end
    end

    // Segment state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined wide adder/subtractor with valid/ready handshake.
// Segment j's operands are skewed by j cycles so they meet the carry from
// segment j-1, and its result is deskewed by SEGS-1-j cycles so a whole
// beat emerges together, SEGS cycles after it was accepted.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = PA_WIDTH,
    parameter int SEGS  = PA_SEGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = seg_width(WIDTH, SEGS);

    logic             en;
    logic [WIDTH-1:0] opb_eff;
    logic             c0;
    logic [SEGS-1:0]  seg_c;
    logic [SEGS-1:0]  seg_v;
    logic [SEGS-1:0]  seg_ovf;
    logic [WIDTH-1:0] sum_all;

    // Global stall and operand conditioning; subtract is a + ~b + ~borrow.
    always_comb begin
        en       = !(out_valid && !out_ready);
        in_ready = en;
        opb_eff  = sub ? ~din_two : din_two;
        c0       = cin ^ sub;
    end

    for (genvar j = 0; j < SEGS; j++) begin : g_seg
        logic [SW-1:0] a_seg;
        logic [SW-1:0] b_seg;
        logic [SW-1:0] s_seg;
        logic          c_seg;
        logic          v_seg;

        if (j == 0) begin : g_head
            assign a_seg = din_one[SW-1:0];
            assign b_seg = opb_eff[SW-1:0];
            assign c_seg = c0;
            assign v_seg = in_valid;
        end else begin : g_skew
            logic [SW-1:0] a_q [j];
            logic [SW-1:0] b_q [j];
            logic [SW-1:0] a_d [j];
            logic [SW-1:0] b_d [j];

            // Operand skew line: j stages before this segment's adder.
            always_comb begin
                for (int i = 0; i < j; i++) begin
                    a_d[i] = a_q[i];
                    b_d[i] = b_q[i];
                end
                if (en) begin
                    a_d[0] = din_one[j*SW +: SW];
                    b_d[0] = opb_eff[j*SW +: SW];
                    for (int i = 1; i < j; i++) begin
                        a_d[i] = a_q[i-1];
                        b_d[i] = b_q[i-1];
                    end
                end
            end

            // Skew registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < j; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < j; i++) begin
                        a_q[i] <= a_d[i];
                        b_q[i] <= b_d[i];
                    end
                end
            end

            assign a_seg = a_q[j-1];
            assign b_seg = b_q[j-1];
            assign c_seg = seg_c[j-1];
            assign v_seg = seg_v[j-1];
        end

        pipe_adder_seg #(
            .SEG_W   (SW),
            .MSB_SEG (j == SEGS - 1)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .vld_in  (v_seg),
            .a       (a_seg),
            .b       (b_seg),
            .c_in    (c_seg),
            .sum_q   (s_seg),
            .c_out_q (seg_c[j]),
            .ovf_q   (seg_ovf[j]),
            .vld_q   (seg_v[j])
        );

        if (j == SEGS - 1) begin : g_nodsk
            assign sum_all[j*SW +: SW] = s_seg;
        end else begin : g_dsk
            localparam int D = SEGS - 1 - j;
            logic [SW-1:0] dsk_q [D];
            logic [SW-1:0] dsk_d [D];

            // Result deskew line: hold early slices until the top slice lands.
            always_comb begin
                for (int i = 0; i < D; i++) begin
                    dsk_d[i] = dsk_q[i];
                end
                if (en) begin
                    dsk_d[0] = s_seg;
                    for (int i = 1; i < D; i++) begin
                        dsk_d[i] = dsk_q[i-1];
                    end
                end
            end

            // Deskew registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        dsk_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < D; i++) begin
                        dsk_q[i] <= dsk_d[i];
                    end
                end
            end

            assign sum_all[j*SW +: SW] = dsk_q[D-1];
        end
    end

    assign out_valid = seg_v[SEGS-1];
    assign sum       = sum_all;
    assign cout      = seg_c[SEGS-1];
    assign ovf       = |seg_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corner cases, stall and reset
// behaviour on a 512/4 instance, and randomized traffic on 64/1 and 64/8.
module tb_pipe_adder;

    logic clk;
    logic rst_n;

    logic         iv_w, ir_w, cin_w, sub_w, ov_w, or_w, co_w, of_w;
    logic [511:0] a_w, b_w, s_w;

    logic [63:0]  a_n, b_n;
    logic         cin_n, sub_n;
    logic         iv_1, ir_1, ov_1, or_1, co_1, of_1;
    logic [63:0]  s_1;
    logic         iv_8, ir_8, ov_8, or_8, co_8, of_8;
    logic [63:0]  s_8;

    int n_chk = 0;
    int n_err = 0;
    int cnt_w = 0;
    int cnt_1 = 0;
    int cnt_8 = 0;

    logic [513:0] q_w [$];
    logic [513:0] q_1 [$];
    logic [513:0] q_8 [$];

    pipe_adder #(.WIDTH(512), .SEGS(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w),
        .din_one(a_w), .din_two(b_w), .cin(cin_w), .sub(sub_w),
        .out_valid(ov_w), .out_ready(or_w), .sum(s_w), .cout(co_w), .ovf(of_w)
    );

    pipe_adder #(.WIDTH(64), .SEGS(1)) u_dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_1), .in_ready(ir_1),
        .din_one(a_n), .din_two(b_n), .cin(cin_n), .sub(sub_n),
        .out_valid(ov_1), .out_ready(or_1), .sum(s_1), .cout(co_1), .ovf(of_1)
    );

    pipe_adder #(.WIDTH(64), .SEGS(8)) u_dut_8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_8), .in_ready(ir_8),
        .din_one(a_n), .din_two(b_n), .cin(cin_n), .sub(sub_n),
        .out_valid(ov_8), .out_ready(or_8), .sum(s_8), .cout(co_8), .ovf(of_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-width arithmetic reference: returns {ovf, cout, sum}.
    function automatic logic [513:0] model(input logic [511:0] a, input logic [511:0] b,
                                           input logic ci, input logic sb, input int w);
        logic [511:0] mask, am, be, s;
        logic [512:0] r;
        logic         co, ov;
        mask = (w == 512) ? {512{1'b1}} : ((512'(1) << w) - 512'(1));
        am   = a & mask;
        be   = sb ? (~b & mask) : (b & mask);
        r    = {1'b0, am} + {1'b0, be} + 513'(sb ? !ci : ci);
        s    = r[511:0] & mask;
        co   = r[w];
        ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One cycle: sample just after the falling edge, score outputs, log
    // accepted beats, then advance to the next falling edge.
    task automatic tick();
        logic [513:0] e;
        #1;
        chk("w_ready", ir_w, !(ov_w && !or_w));
        chk("s1_ready", ir_1, !(ov_1 && !or_1));
        chk("s8_ready", ir_8, !(ov_8 && !or_8));
        if (ov_w) begin
            if (q_w.size() == 0) chk("w_spurious", ov_w, 0);
            else begin
                e = q_w[0];
                chk("w_sum", s_w, e[511:0]);
                chk("w_cout", co_w, e[512]);
                chk("w_ovf", of_w, e[513]);
                if (or_w) void'(q_w.pop_front());
            end
        end
        if (ov_1) begin
            if (q_1.size() == 0) chk("s1_spurious", ov_1, 0);
            else begin
                e = q_1[0];
                chk("s1_sum", s_1, e[63:0]);
                chk("s1_cout", co_1, e[512]);
                chk("s1_ovf", of_1, e[513]);
                if (or_1) void'(q_1.pop_front());
            end
        end
        if (ov_8) begin
            if (q_8.size() == 0) chk("s8_spurious", ov_8, 0);
            else begin
                e = q_8[0];
                chk("s8_sum", s_8, e[63:0]);
                chk("s8_cout", co_8, e[512]);
                chk("s8_ovf", of_8, e[513]);
                if (or_8) void'(q_8.pop_front());
            end
        end
        if (iv_w && ir_w) begin
            q_w.push_back(model(a_w, b_w, cin_w, sub_w, 512));
            cnt_w++;
        end
        if (iv_1 && ir_1) begin
            q_1.push_back(model(512'(a_n), 512'(b_n), cin_n, sub_n, 64));
            cnt_1++;
        end
        if (iv_8 && ir_8) begin
            q_8.push_back(model(512'(a_n), 512'(b_n), cin_n, sub_n, 64));
            cnt_8++;
        end
        @(negedge clk);
    endtask

    // Single beat into the idle wide instance; measures latency and checks
    // the result against the given expected values.
    task automatic run_dir(input string tag, input logic [511:0] a, input logic [511:0] b,
                           input logic ci, input logic sb,
                           input logic [511:0] es, input logic ec, input logic eo);
        int lat;
        a_w = a; b_w = b; cin_w = ci; sub_w = sb; iv_w = 1'b1; or_w = 1'b1;
        tick();
        iv_w = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            if (ov_w) begin
                lat = i;
                break;
            end
            tick();
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, s_w, es);
        chk({tag, "_cout"}, co_w, ec);
        chk({tag, "_ovf"}, of_w, eo);
        tick();
    endtask

    initial begin
        logic [511:0] ones, t1, t2;
        logic [513:0] e;
        int base, prev, st1, st8, lat1, lat8;

        rst_n = 1'b0;
        iv_w = 1'b0; or_w = 1'b1; a_w = '0; b_w = '0; cin_w = 1'b0; sub_w = 1'b0;
        iv_1 = 1'b0; or_1 = 1'b1; iv_8 = 1'b0; or_8 = 1'b1;
        a_n = '0; b_n = '0; cin_n = 1'b0; sub_n = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_ov", ov_w, 0);
        chk("rst_rdy", ir_w, 1);
        chk("rst_sum", s_w, 0);
        chk("rst_cout", co_w, 0);
        chk("rst_ovf", of_w, 0);
        chk("rst_ov1", ov_1, 0);
        chk("rst_ov8", ov_8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        ones = {512{1'b1}};
        t1 = ones << 1;
        t2 = ones >> 1;
        run_dir("inc_wrap", ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        run_dir("sub_neg", 512'd5, 512'd7, 1'b0, 1'b1, t1, 1'b0, 1'b0);
        run_dir("sub_pos", 512'd7, 512'd5, 1'b0, 1'b1, 512'd2, 1'b1, 1'b0);
        run_dir("ovf_pos", t2, 512'd1, 1'b0, 1'b0, 512'(1) << 511, 1'b0, 1'b1);

        // Back-to-back beats with out_ready dropped for cycles 5..7.
        base = cnt_w;
        a_w = rnd512(); b_w = rnd512(); cin_w = 1'($urandom); sub_w = 1'($urandom);
        for (int c = 0; c < 25; c++) begin
            iv_w = (cnt_w - base) < 8;
            or_w = !(c >= 5 && c <= 7);
            prev = cnt_w;
            #1;
            if (c <= 12) chk("b2b_ready", ir_w, !(c >= 5 && c <= 7));
            tick();
            if (cnt_w != prev) begin
                a_w = rnd512(); b_w = rnd512(); cin_w = 1'($urandom); sub_w = 1'($urandom);
            end
        end
        iv_w = 1'b0; or_w = 1'b1;
        chk("b2b_beats", cnt_w - base, 8);
        chk("b2b_drain", q_w.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            a_w = rnd512(); b_w = rnd512(); cin_w = 1'($urandom); sub_w = 1'($urandom);
            iv_w = 1'b1;
            tick();
        end
        iv_w = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", ov_w, 0);
        chk("arst_sum", s_w, 0);
        chk("arst_cout", co_w, 0);
        q_w.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("arst_stale", ov_w, 0);
        end
        t1 = rnd512(); t2 = rnd512();
        e = model(t1, t2, 1'b1, 1'b0, 512);
        run_dir("post_rst", t1, t2, 1'b1, 1'b0, e[511:0], e[512], e[513]);

        // Latency of the 64-bit instances from idle.
        a_n = {$urandom, $urandom}; b_n = {$urandom, $urandom};
        cin_n = 1'($urandom); sub_n = 1'($urandom);
        iv_1 = 1'b1; iv_8 = 1'b1;
        tick();
        iv_1 = 1'b0; iv_8 = 1'b0;
        lat1 = 0; lat8 = 0;
        for (int i = 1; i <= 12; i++) begin
            if (ov_1 && lat1 == 0) lat1 = i;
            if (ov_8 && lat8 == 0) lat8 = i;
            tick();
        end
        chk("s1_lat", lat1, 1);
        chk("s8_lat", lat8, 8);

        // Random add/sub traffic with random back-pressure.
        st1 = cnt_1; st8 = cnt_8;
        for (int cyc = 0; cyc < 40000 && ((cnt_1 - st1) < 10000 || (cnt_8 - st8) < 10000); cyc++) begin
            a_n = {$urandom, $urandom}; b_n = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) a_n = {1'b0, {63{1'b1}}};
            if ($urandom_range(0, 15) == 0) b_n = '1;
            cin_n = 1'($urandom); sub_n = 1'($urandom);
            iv_1 = ((cnt_1 - st1) < 10000) && ($urandom_range(0, 9) < 8);
            iv_8 = ((cnt_8 - st8) < 10000) && ($urandom_range(0, 9) < 8);
            or_1 = $urandom_range(0, 3) != 0;
            or_8 = $urandom_range(0, 3) != 0;
            tick();
        end
        iv_1 = 1'b0; iv_8 = 1'b0; or_1 = 1'b1; or_8 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("s1_beats", cnt_1 - st1, 10000);
        chk("s8_beats", cnt_8 - st8, 10000);
        chk("s1_drain", q_1.size(), 0);
        chk("s8_drain", q_8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
